// File: rtl/text_write_arbiter.sv
// text_write_arbiter: shares the single write port of the ASCII text-buffer controller between
// the CPU store path (requester 0) and the register-dump debug sequencer (requester 1). Adds a
// hardware clear-screen sequencer and drops out-of-range writes, flagging them in addr_err.
// Optional build macro TEXT_ARB_STATS_EN adds per-requester saturating write counters.
module text_write_arbiter #(
    parameter int unsigned       ADDR_W     = 13,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       TEXT_CELLS = 4800,
    parameter logic [DATA_W-1:0] BLANK_WORD = 32'h20FFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ack,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              addr_err
`ifdef TEXT_ARB_STATS_EN
    ,
    output logic [15:0]       cpu_wr_count,
    output logic [15:0]       dbg_wr_count
`endif
);

    typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

    localparam logic [ADDR_W-1:0] LastCell = ADDR_W'(TEXT_CELLS - 1);

    state_e            state_q, state_d;
    logic              rr_last_q, rr_last_d;   // 1: debug was granted last
    logic              grant_q, grant_d;       // 1: debug owns the current write
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              addr_err_q, addr_err_d;

    logic in_range;
    logic clr_last;
    logic pick_dbg;

    assign in_range = (wr_addr_q <= LastCell);
    assign clr_last = (clr_cnt_q == LastCell);
    // Debug wins when it is alone, or on a tie when the CPU was served last.
    assign pick_dbg = dbg_req & (~cpu_req | ~rr_last_q);

    // State register; async reset forces IDLE, which drops wr_en/acks/clr_busy at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear has priority over requests, WRITE lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                end else if (cpu_req || dbg_req) begin
                    state_d = StWrite;
                end
            end
            StWrite: state_d = StIdle;
            StClear: begin
                if (clr_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: grant latching, clear address walk, sticky error.
    always_comb begin
        rr_last_d  = rr_last_q;
        grant_d    = grant_q;
        clr_cnt_d  = clr_cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        addr_err_d = addr_err_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    clr_cnt_d = '0;
                    wr_addr_d = '0;
                    wr_data_d = BLANK_WORD;
                end else if (cpu_req || dbg_req) begin
                    grant_d   = pick_dbg;
                    rr_last_d = pick_dbg;
                    wr_addr_d = pick_dbg ? dbg_addr : cpu_addr;
                    wr_data_d = pick_dbg ? dbg_data : cpu_data;
                end
            end
            StWrite: begin
                if (!in_range) begin
                    addr_err_d = 1'b1;
                end
            end
            StClear: begin
                // wr_addr tracks clr_cnt and keeps the last cleared cell once done.
                if (clr_last) begin
                    addr_err_d = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    wr_addr_d = clr_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_q  <= 1'b1;
            grant_q    <= 1'b0;
            clr_cnt_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rr_last_q  <= rr_last_d;
            grant_q    <= grant_d;
            clr_cnt_q  <= clr_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Outputs decoded from state; a dropped write shows addr_err in its own ack cycle.
    always_comb begin
        cpu_ack  = 1'b0;
        dbg_ack  = 1'b0;
        wr_en    = 1'b0;
        clr_busy = 1'b0;
        addr_err = addr_err_q;
        unique case (state_q)
            StWrite: begin
                cpu_ack  = ~grant_q;
                dbg_ack  = grant_q;
                wr_en    = in_range;
                addr_err = addr_err_q | ~in_range;
            end
            StClear: begin
                wr_en    = 1'b1;
                clr_busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

`ifdef TEXT_ARB_STATS_EN
    logic [15:0] cpu_cnt_q, dbg_cnt_q;

    // Saturating counts of in-range writes issued per requester; untouched by clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_cnt_q <= '0;
            dbg_cnt_q <= '0;
        end else if (state_q == StWrite && in_range) begin
            if (!grant_q && cpu_cnt_q != 16'hFFFF) begin
                cpu_cnt_q <= cpu_cnt_q + 16'd1;
            end
            if (grant_q && dbg_cnt_q != 16'hFFFF) begin
                dbg_cnt_q <= dbg_cnt_q + 16'd1;
            end
        end
    end

    assign cpu_wr_count = cpu_cnt_q;
    assign dbg_wr_count = dbg_cnt_q;
`endif

endmodule

// File: tb/tb_text_write_arbiter.sv
// Self-checking bench for text_write_arbiter: directed steps push expected write-port activity
// into a queue; a negedge monitor pops and compares every cycle that shows wr_en or an ack.
module tb_text_write_arbiter;

    localparam int unsigned ADDR_W     = 13;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned TEXT_CELLS = 4800;
    localparam logic [31:0] BLANK      = 32'h20FFFFFF;

    logic              clk;
    logic              rst;
    logic              cpu_req, dbg_req, clr_req;
    logic [ADDR_W-1:0] cpu_addr, dbg_addr;
    logic [DATA_W-1:0] cpu_data, dbg_data;
    logic              cpu_ack, dbg_ack, clr_busy, wr_en, addr_err;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
`ifdef TEXT_ARB_STATS_EN
    logic [15:0]       cpu_wr_count, dbg_wr_count;
`endif

    text_write_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .cpu_ack  (cpu_ack),
        .dbg_req  (dbg_req),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .dbg_ack  (dbg_ack),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .addr_err (addr_err)
`ifdef TEXT_ARB_STATS_EN
        ,
        .cpu_wr_count (cpu_wr_count),
        .dbg_wr_count (dbg_wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              cpu_ack;
        logic              dbg_ack;
        logic              wr_en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_write(input bit is_dbg, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
        exp_t e;
        e.cpu_ack = !is_dbg;
        e.dbg_ack = is_dbg;
        e.wr_en   = (int'(a) < int'(TEXT_CELLS));
        e.addr    = a;
        e.data    = d;
        sb.push_back(e);
    endtask

    task automatic push_clear(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cpu_ack = 1'b0;
            e.dbg_ack = 1'b0;
            e.wr_en   = 1'b1;
            e.addr    = ADDR_W'(i);
            e.data    = BLANK;
            sb.push_back(e);
        end
    endtask

    // One request held until its ack (bounded), then released; ends back in IDLE.
    task automatic single_write(input bit is_dbg, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input int budget);
        logic got;
        push_write(is_dbg, a, d);
        if (is_dbg) begin
            dbg_addr = a; dbg_data = d; dbg_req = 1'b1;
        end else begin
            cpu_addr = a; cpu_data = d; cpu_req = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((is_dbg ? dbg_ack : cpu_ack) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_seen", 64'(got), 64'd1);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        tick();
    endtask

    task automatic start_clear();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic done;
        rst = 1'b0;
        cpu_req = 1'b0; dbg_req = 1'b0; clr_req = 1'b0;
        cpu_addr = '0; dbg_addr = '0; cpu_data = '0; dbg_data = '0;

        // Scoreboard monitor: every cycle with write-port activity must match the next entry.
        fork
            forever begin
                @(negedge clk);
                if (wr_en === 1'b1 || cpu_ack === 1'b1 || dbg_ack === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $error("FAIL unexpected_write observed=%0h expected=none",
                               {cpu_ack, dbg_ack, wr_en, wr_addr, wr_data});
                    end else begin
                        e = sb.pop_front();
                        check("write", 64'({cpu_ack, dbg_ack, wr_en, wr_addr, wr_data}), 64'(e));
                    end
                end
            end
        join_none

        // Reset state.
        #12;
        check("rst_outputs", 64'({cpu_ack, dbg_ack, clr_busy, wr_en, addr_err}), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
`ifdef TEXT_ARB_STATS_EN
        check("rst_counts", 64'({cpu_wr_count, dbg_wr_count}), 64'd0);
`endif
        tick();
        rst = 1'b1;
        tick();

        // CPU alone, request held: write, idle cycle, write again.
        push_write(1'b0, 13'd5, 32'h41FFFFFF);
        push_write(1'b0, 13'd5, 32'h41FFFFFF);
        cpu_addr = 13'd5; cpu_data = 32'h41FFFFFF; cpu_req = 1'b1;
        tick();
        check("cpu_first_ack", 64'(cpu_ack), 64'd1);
        tick();
        check("cpu_gap_wr_en", 64'(wr_en), 64'd0);
        check("cpu_gap_hold_addr", 64'(wr_addr), 64'd5);
        tick();
        cpu_req = 1'b0;
        tick(2);

        // Tie from reset: CPU, DBG, CPU, DBG.
        rst = 1'b0;
        #1;
        cpu_addr = 13'd10; cpu_data = 32'h43112233;
        dbg_addr = 13'd20; dbg_data = 32'h44445566;
        cpu_req = 1'b1; dbg_req = 1'b1;
        push_write(1'b0, 13'd10, 32'h43112233);
        push_write(1'b1, 13'd20, 32'h44445566);
        push_write(1'b0, 13'd10, 32'h43112233);
        push_write(1'b1, 13'd20, 32'h44445566);
        tick();
        rst = 1'b1;
        tick(7);
        check("tie_last_dbg_ack", 64'(dbg_ack), 64'd1);
        cpu_req = 1'b0; dbg_req = 1'b0;
        tick(2);
        check("tie_drained", 64'(sb.size()), 64'd0);

        // Out-of-range debug write is acked but dropped; error is sticky.
        single_write(1'b1, 13'd4800, 32'h58FFFFFF, 10);
        check("range_err_set", 64'(addr_err), 64'd1);
        single_write(1'b0, 13'd4799, 32'h5AFFFFFF, 10);
        check("range_err_sticky", 64'(addr_err), 64'd1);

        // Full clear, with a CPU request raised midway that waits for the clear.
        push_clear(int'(TEXT_CELLS));
        start_clear();
        check("clr_busy_set", 64'(clr_busy), 64'd1);
        tick(2000);
        push_write(1'b0, 13'd7, 32'h47ABCDEF);
        cpu_addr = 13'd7; cpu_data = 32'h47ABCDEF; cpu_req = 1'b1;
        tick();
        check("clr_mid_addr", 64'(wr_addr), 64'd2001);
        check("clr_mid_no_ack", 64'(cpu_ack), 64'd0);
        done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (clr_busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        check("clr_finished", 64'(done), 64'd1);
        check("clr_err_cleared", 64'(addr_err), 64'd0);
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_ack === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        check("clr_pending_ack", 64'(done), 64'd1);
        cpu_req = 1'b0;
        tick(2);
        check("clr_drained", 64'(sb.size()), 64'd0);

        // Reset in the middle of a clear, with addr_err set beforehand.
        single_write(1'b0, 13'd5000, 32'h01020304, 10);
        check("mid_err_set", 64'(addr_err), 64'd1);
        push_clear(100);
        start_clear();
        tick(100);
        check("mid_clr_addr", 64'(wr_addr), 64'd100);
        rst = 1'b0;
        #1;
        check("mid_rst_outputs", 64'({cpu_ack, dbg_ack, clr_busy, wr_en, addr_err}), 64'd0);
        check("mid_rst_addr", 64'(wr_addr), 64'd0);
        tick();
        rst = 1'b1;
        tick(3);
        check("mid_rel_idle", 64'({clr_busy, wr_en}), 64'd0);
        single_write(1'b1, 13'd33, 32'h21FF0000, 10);

        // Three in-range CPU writes plus one dropped one.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        single_write(1'b0, 13'd1, 32'h31FFFFFF, 10);
        single_write(1'b0, 13'd2, 32'h32FFFFFF, 10);
        single_write(1'b0, 13'd8191, 32'h39FFFFFF, 10);
        single_write(1'b0, 13'd3, 32'h33FFFFFF, 10);
`ifdef TEXT_ARB_STATS_EN
        check("stats_cpu", 64'(cpu_wr_count), 64'd3);
        check("stats_dbg", 64'(dbg_wr_count), 64'd0);
`endif
        tick(2);
        check("final_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
